ram_reader: RTL
===============

# ram_reader

Burst read engine for the byte-wide dual-port RAM: the reading end paired with the RAM's write port. It accepts a start address and byte count, drives the RAM read address, and streams the bytes out on a valid/ready interface at up to one byte per clock. It sits beside the RAM at the top level. Writers own `add_w`/`w_sig`; this block owns `add_r`.

## Interface
- `width`, 8: data width in bits; must match the RAM `width`.
- `depth`, 8: address width; RAM holds 2**depth words.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `add_s`  in  depth  start address, sampled with `start`.
- `len`  in  depth+1  number of bytes, 0..2**depth.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `add_r`  out  depth  RAM read address; RAM `dout` is combinational from it.
- `ram_q`  in  width  RAM `dout`.
- `dout`  out  width  output byte.
- `dout_v`  out  1  `dout` valid.
- `dout_rdy`  in  1  consumer ready; a transfer occurs on an edge where `dout_v && dout_rdy`.
- `done`  out  1  one-cycle pulse at burst completion.
- `last`  out  1  present only with RAM_READER_LAST_EN; see Configuration.

## Operation
- Reset values: `busy`=0, `add_r`=0, `dout`=0, `dout_v`=0, `done`=0, `last`=0. State is IDLE and the remaining count is 0.
- States: IDLE, RUN, FLUSH.
- **IDLE:**
  - `start` with `len`>0: load `ptr`=`add_s` and `rem`=`len`, then go to RUN.
  - `start` with `len`=0: pulse `done` next cycle, stay IDLE, produce no output.
- **RUN:**
  - `add_r` = `ptr`.
  - The output register loads when `!dout_v || dout_rdy`. On a load: `dout`←`ram_q`, `dout_v`←1, `ptr`←`ptr`+1 mod 2**depth, `rem`←`rem`−1.
  - When the load takes `rem` from 1 to 0, go to FLUSH.
- **FLUSH:** hold `dout` until the final transfer. On that edge: `dout_v`←0, `done`←1 for one cycle, state←IDLE.
- Backpressure: while `dout_v && !dout_rdy`, `dout`, `ptr`, `rem` and `add_r` hold.
- Address wrap: the pointer wraps from 2**depth−1 to 0.
- `len`=2**depth: reads every word exactly once, ending at `add_s`−1.
- `start` while not IDLE is ignored.
- Concurrent RAM write to the address being captured on the same edge: the reader captures the pre-write value, because the RAM updates non-blocking.
- `rst` mid-burst: return to IDLE immediately and drop the in-flight byte. No `done` pulse. All outputs take reset values after the edge.

## Timing
- `start` accepted at edge k:
  - `busy`=1 and `add_r`=`add_s` after edge k.
  - First byte valid after edge k+1.
- Throughput with `dout_rdy` held high: one byte per cycle, so a burst of N bytes has `dout_v` high for N consecutive cycles.
- `done` is high in the cycle after the final transfer edge. `busy` falls in that same cycle.
- Back-to-back: `start` may be asserted during the `done` cycle, since the state is already IDLE.
- Minimum command spacing: N+2 cycles with `dout_rdy`=1.

## Configuration
- `RAM_READER_LAST_EN` defined:
  - The `last` port exists. It is registered alongside `dout` and is high exactly while `dout_v` carries the final byte of a burst.
  - It resets to 0 and clears on the final transfer.
- `RAM_READER_LAST_EN` undefined:
  - No `last` port and no associated logic.
  - All other behaviour is identical.

## Structure
- Shared package `ram_pkg`:
  - state encoding constants `S_IDLE`, `S_RUN`, `S_FLUSH`;
  - default `WIDTH`=8 and `DEPTH`=8, used by both `ram` and `ram_reader`.
- No sub-module. The RAM is instantiated next to `ram_reader` at top level, not inside it.

## Test plan
- Preload RAM[0x10..0x13]=A0,A1,A2,A3. `start`, `add_s`=0x10, `len`=4, `dout_rdy`=1 → `dout` A0..A3 on 4 consecutive cycles, first valid 2 cycles after `start`. `done` pulses the cycle after A3.
- Same burst with `dout_rdy` toggling 1,0,0,1,… → each byte held stable while stalled, no duplicates or losses, order A0..A3.
- `add_s`=0xFE, `len`=4, RAM[FE,FF,00,01]=1,2,3,4 → output 1,2,3,4, showing wrap to 0.
- `len`=0 → `done` pulse next cycle, `dout_v` never high, `busy` stays 0. `len`=256 → 256 bytes covering all addresses once.
- `rst` after the 2nd byte of an 8-byte burst → next cycle all outputs 0 and no `done`. A new `start` then runs normally.
- With RAM_READER_LAST_EN, `len`=3 → `last` high only alongside the 3rd byte. Without the macro, the port is absent.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM sizing defaults and ram_reader state encoding
package ram_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - burst read engine streaming RAM bytes on a valid/ready output
// Optional RAM_READER_LAST_EN adds a registered last-byte flag alongside dout.
module ram_reader
    import ram_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int depth = DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [depth-1:0] add_s,
    input  logic [depth:0]   len,
    output logic             busy,
    output logic [depth-1:0] add_r,
    input  logic [width-1:0] ram_q,
    output logic [width-1:0] dout,
    output logic             dout_v,
    input  logic             dout_rdy,
    output logic             done
`ifdef RAM_READER_LAST_EN
    ,
    output logic             last
`endif
);

    localparam logic [depth:0] REM_ONE = (depth + 1)'(1);

    state_t           state_q, state_d;
    logic [depth-1:0] ptr_q, ptr_d;
    logic [depth:0]   rem_q, rem_d;
    logic [width-1:0] dout_q, dout_d;
    logic             dout_v_q, dout_v_d;
    logic             done_q, done_d;
    logic             load;
`ifdef RAM_READER_LAST_EN
    logic             last_q, last_d;
`endif

    // The output register refills whenever it is empty or being drained this edge.
    assign load = !dout_v_q || dout_rdy;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        dout_d   = dout_q;
        dout_v_d = dout_v_q;
        done_d   = 1'b0;
`ifdef RAM_READER_LAST_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        ptr_d   = add_s;
                        rem_d   = len;
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (load) begin
                    dout_d   = ram_q;
                    dout_v_d = 1'b1;
                    ptr_d    = ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
`ifdef RAM_READER_LAST_EN
                    last_d   = (rem_q == REM_ONE);
`endif
                    if (rem_q == REM_ONE) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (dout_rdy) begin
                    dout_v_d = 1'b0;
                    done_d   = 1'b1;
`ifdef RAM_READER_LAST_EN
                    last_d   = 1'b0;
`endif
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            dout_q   <= '0;
            dout_v_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef RAM_READER_LAST_EN
            last_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            dout_q   <= dout_d;
            dout_v_q <= dout_v_d;
            done_q   <= done_d;
`ifdef RAM_READER_LAST_EN
            last_q   <= last_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign add_r  = ptr_q;
    assign dout   = dout_q;
    assign dout_v = dout_v_q;
    assign done   = done_q;
`ifdef RAM_READER_LAST_EN
    assign last   = last_q;
`endif

endmodule
